// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port, 1-cycle-latency frame-buffer RAM between the
// VGA display fetch and two pixel writers (road renderer wr0, status overlay wr1).
//
// Each 4-clock pixel period is split into phases locked to the pclk pulse. Phase 1 belongs
// to the display fetch while DE is high; every other cycle is a write slot shared
// round-robin between the writers. The 320x240 frame buffer is upscaled 2x to 640x480.
//
// Ports:
//   clk, reset        system clock; asynchronous active-low reset
//   pclk              1-in-4 pixel-clock pulse, phase reference
//   DE, x_pixel,      visible-area enable and current 640x480 position
//   y_pixel
//   wrN_req/addr/data writer requests (held until granted), wrN_gnt 1-clk grant pulse
//   mem_*             RAM port; mem_rdata valid 1 clk after a read
//   pix_data          registered pixel, updated at the start of phase 3
//   fetch_miss        sticky: pclk arrived outside phase 3 (cleared only by reset)
module vga_fb_arbiter #(
  parameter int unsigned FB_W   = 320,
  parameter int unsigned FB_H   = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pclk,
  input  logic              DE,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              fetch_miss
);

  if (FB_W * FB_H > (1 << ADDR_W)) begin : g_addr_w_check
    $error("ADDR_W too narrow for FB_W*FB_H");
  end

  typedef enum logic [1:0] {Ph0, Ph1, Ph2, Ph3} phase_e;

  phase_e            r_phase;
  phase_e            w_phase_d;
  logic              r_last;   // writer granted most recently (1 = wr1)
  logic              r_de_p1;  // DE as seen during the phase-1 fetch slot
  logic [DATA_W-1:0] r_pix;
  logic              r_miss;

  logic              w_fetch;
  logic              w_g0;
  logic              w_g1;
  logic [ADDR_W-1:0] w_rd_addr;

  // 2x downscale of the display position into the frame buffer.
  assign w_rd_addr = ADDR_W'(y_pixel >> 1) * ADDR_W'(FB_W) + ADDR_W'(x_pixel >> 1);

  // Phase sequencer: pclk always forces phase 0 next, even when early (resync).
  always_comb begin
    w_phase_d = phase_e'(r_phase + 2'd1);
    if (pclk) begin
      w_phase_d = Ph0;
    end
  end

  // Slot decode and RAM drive. Outputs are forced low while reset is asserted so a
  // write in flight is abandoned immediately rather than at the next edge.
  always_comb begin
    w_fetch   = 1'b0;
    w_g0      = 1'b0;
    w_g1      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      w_fetch = (r_phase == Ph1) && DE;
      if (!w_fetch) begin
        // On a tie wr0 wins only if wr1 had the last grant.
        if (wr0_req && (!wr1_req || r_last)) begin
          w_g0 = 1'b1;
        end else if (wr1_req) begin
          w_g1 = 1'b1;
        end
      end
      if (w_fetch) begin
        mem_en   = 1'b1;
        mem_addr = w_rd_addr;
      end else if (w_g0) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr0_addr;
        mem_wdata = wr0_data;
      end else if (w_g1) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr1_addr;
        mem_wdata = wr1_data;
      end
    end
  end

  assign wr0_gnt = w_g0;
  assign wr1_gnt = w_g1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= Ph3;
      r_last  <= 1'b1;
      r_de_p1 <= 1'b0;
      r_pix   <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_phase <= w_phase_d;
      if (pclk && (r_phase != Ph3)) begin
        r_miss <= 1'b1;
      end
      if (w_g0) begin
        r_last <= 1'b0;
      end else if (w_g1) begin
        r_last <= 1'b1;
      end
      if (r_phase == Ph1) begin
        r_de_p1 <= DE;
      end
      // RAM data for the phase-1 read is valid during phase 2; blank when DE was low.
      if (r_phase == Ph2) begin
        r_pix <= r_de_p1 ? mem_rdata : '0;
      end
    end
  end

  assign pix_data   = r_pix;
  assign fetch_miss = r_miss;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: randomized and directed stimulus, a behavioural model
// that predicts every cycle's RAM port, grants, pixel and miss flag into a queue, and a
// monitor that compares the DUT against that queue on the falling edge.
module tb_vga_fb_arbiter;
  localparam int unsigned FB_W   = 320;
  localparam int unsigned FB_H   = 240;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned NPIX   = FB_W * FB_H;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pclk = 1'b0;
  logic              DE = 1'b0;
  logic [9:0]        x_pixel = '0;
  logic [9:0]        y_pixel = '0;
  logic              wr0_req = 1'b0;
  logic [ADDR_W-1:0] wr0_addr = '0;
  logic [DATA_W-1:0] wr0_data = '0;
  logic              wr0_gnt;
  logic              wr1_req = 1'b0;
  logic [ADDR_W-1:0] wr1_addr = '0;
  logic [DATA_W-1:0] wr1_data = '0;
  logic              wr1_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] pix_data;
  logic              fetch_miss;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pclk      (pclk),
    .DE        (DE),
    .x_pixel   (x_pixel),
    .y_pixel   (y_pixel),
    .wr0_req   (wr0_req),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr0_gnt   (wr0_gnt),
    .wr1_req   (wr1_req),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .wr1_gnt   (wr1_gnt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .fetch_miss(fetch_miss)
  );

  // Frame-buffer RAM driven by the DUT.
  logic [DATA_W-1:0] ram [NPIX];
  always @(posedge clk) begin
    if (mem_en && (int'(mem_addr) < int'(NPIX))) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              g0;
    logic              g1;
    logic [DATA_W-1:0] pix;
    logic              miss;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic string fmt(input obs_t o);
    return $sformatf("en=%b we=%b addr=%0d wd=%h g0=%b g1=%b pix=%h miss=%b",
                     o.en, o.we, o.addr, o.wdata, o.g0, o.g1, o.pix, o.miss);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] mram [NPIX];
  int                m_phase;   // phase of the cycle being driven
  int                m_last;    // writer granted most recently
  bit                m_miss;
  logic [DATA_W-1:0] m_pix;
  logic [DATA_W-1:0] m_fetch;   // pixel fetched in the latest phase-1 slot
  bit                p_valid;   // previous cycle's effects still to be applied
  int                p_phase;
  bit                p_pclk;
  int                p_gnt;
  int                p_waddr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_fetch_val;

  // ---------------- stimulus controls ----------------
  bit                rand_xy = 1'b0;
  bit                s_de = 1'b0;
  int                s_x = 0;
  int                s_y = 0;
  bit                early = 1'b0;
  int                w_mode [2] = '{0, 0};  // 0 idle, 1 fixed request, 2 random
  int                w_afix [2] = '{0, 0};
  logic [DATA_W-1:0] w_dfix [2] = '{12'h000, 12'h000};
  bit                w_granted [2] = '{1'b0, 1'b0};
  bit                rq [2] = '{1'b0, 1'b0};
  int                ad [2] = '{0, 0};
  logic [DATA_W-1:0] dt [2] = '{12'h000, 12'h000};

  task automatic model_reset();
    m_phase = 3;
    m_last  = 1;
    m_miss  = 1'b0;
    m_pix   = '0;
    m_fetch = '0;
    p_valid = 1'b0;
    w_granted[0] = 1'b0;
    w_granted[1] = 1'b0;
  endtask

  task automatic model_commit();
    if (!p_valid) return;
    if (p_gnt >= 0) begin
      mram[p_waddr] = p_wdata;
      m_last = p_gnt;
    end
    if (p_phase == 1) m_fetch = p_fetch_val;
    if (p_phase == 2) m_pix = m_fetch;
    if (p_pclk) begin
      if (p_phase != 3) m_miss = 1'b1;
      m_phase = 0;
    end else begin
      m_phase = (p_phase + 1) % 4;
    end
  endtask

  // Drive this cycle's inputs and queue the expected DUT response.
  task automatic drive_eval();
    obs_t e;
    int   rd;
    int   gnt;
    bit   fetch;
    pclk = (m_phase == 3) || (early && m_phase == 1);
    if (early && m_phase == 1) early = 1'b0;
    if (m_phase == 0) begin
      if (rand_xy) begin
        DE = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) begin
          x_pixel = 10'($urandom_range(0, 639));
          y_pixel = 10'($urandom_range(0, 479));
        end else begin
          x_pixel = 10'($urandom_range(0, 15));
          y_pixel = 10'($urandom_range(0, 7));
        end
      end else begin
        DE = s_de;
        x_pixel = 10'(s_x);
        y_pixel = 10'(s_y);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (w_mode[i] == 0) begin
        rq[i] = 1'b0;
      end else if (w_mode[i] == 1) begin
        rq[i] = 1'b1;
        ad[i] = w_afix[i];
        dt[i] = w_dfix[i];
      end else if (!(rq[i] && !w_granted[i]) || $urandom_range(0, 15) == 0) begin
        rq[i] = ($urandom_range(0, 1) == 1);
        ad[i] = int'($urandom_range(0, 3)) * int'(FB_W) + int'($urandom_range(0, 7));
        dt[i] = DATA_W'($urandom);
      end
    end
    wr0_req = rq[0]; wr0_addr = ADDR_W'(ad[0]); wr0_data = dt[0];
    wr1_req = rq[1]; wr1_addr = ADDR_W'(ad[1]); wr1_data = dt[1];

    e = '0;
    e.pix  = m_pix;
    e.miss = m_miss;
    rd    = (int'(y_pixel) / 2) * int'(FB_W) + int'(x_pixel) / 2;
    fetch = (m_phase == 1) && DE;
    gnt   = -1;
    if (fetch) begin
      e.en   = 1'b1;
      e.addr = ADDR_W'(rd);
    end else begin
      if (rq[0] && rq[1]) gnt = (m_last == 0) ? 1 : 0;
      else if (rq[0])     gnt = 0;
      else if (rq[1])     gnt = 1;
      if (gnt >= 0) begin
        e.en    = 1'b1;
        e.we    = 1'b1;
        e.addr  = ADDR_W'(ad[gnt]);
        e.wdata = dt[gnt];
        e.g0    = (gnt == 0);
        e.g1    = (gnt == 1);
      end
    end
    exp_q.push_back(e);
    p_valid     = 1'b1;
    p_phase     = m_phase;
    p_pclk      = pclk;
    p_gnt       = gnt;
    p_waddr     = (gnt >= 0) ? ad[gnt] : 0;
    p_wdata     = (gnt >= 0) ? dt[gnt] : '0;
    p_fetch_val = fetch ? mram[rd] : '0;
    w_granted[0] = (gnt == 0);
    w_granted[1] = (gnt == 1);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_commit();
      #1;
      drive_eval();
    end
  endtask

  // Assert reset between edges, check every output is forced low, release after n clocks.
  task automatic do_reset(input string name, input int n);
    obs_t a;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    a = '{mem_en, mem_we, mem_addr, mem_wdata, wr0_gnt, wr1_gnt, pix_data, fetch_miss};
    check(name, a, '0);
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    drive_eval();
  endtask

  // Monitor: one comparison per predicted cycle.
  initial begin
    obs_t a;
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{mem_en, mem_we, mem_addr, mem_wdata, wr0_gnt, wr1_gnt, pix_data, fetch_miss};
        check("cycle", a, e);
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(NPIX); i++) begin
      ram[i]  = DATA_W'(i * 37 + 5);
      mram[i] = DATA_W'(i * 37 + 5);
    end
    ram[0]      = 12'hABC;
    mram[0]     = 12'hABC;
    ram[76799]  = 12'h5A5;
    mram[76799] = 12'h5A5;

    // Reset and first fetch from address 0.
    s_de = 1'b1; s_x = 0; s_y = 0;
    do_reset("reset_outputs", 5);
    step(16);

    // Bottom-right corner maps to the last frame-buffer word.
    s_x = 639; s_y = 479;
    step(12);

    // Single writer during the visible area: no grant in phase 1.
    s_x = 0; s_y = 0;
    w_mode[0] = 1; w_afix[0] = 5; w_dfix[0] = 12'h123;
    step(12);
    w_mode[0] = 0;

    // Blanking: both writers hold requests, grant every cycle, pixel goes black.
    s_de = 1'b0;
    w_mode[0] = 1; w_afix[0] = 6; w_dfix[0] = 12'h456;
    w_mode[1] = 1; w_afix[1] = 7; w_dfix[1] = 12'h789;
    step(12);
    w_mode[0] = 0; w_mode[1] = 0;

    // Early pclk: resync and sticky miss, cleared only by reset.
    s_de = 1'b1; s_x = 4; s_y = 2;
    early = 1'b1;
    step(12);
    do_reset("reset_clears_miss", 2);
    step(8);

    // Reset in the middle of a wr1 write; wr0 wins the first tie afterwards.
    s_de = 1'b0;
    w_mode[1] = 1; w_afix[1] = 9; w_dfix[1] = 12'hF0F;
    step(5);
    w_mode[0] = 1; w_afix[0] = 10; w_dfix[0] = 12'h0F0;
    do_reset("reset_midwrite", 3);
    step(8);
    w_mode[0] = 0; w_mode[1] = 0;

    // Random traffic.
    rand_xy = 1'b1;
    w_mode[0] = 2; w_mode[1] = 2;
    step(3000);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
